fetch_queue: RTL and testbench



---
 rtl/fetch_queue.sv | 174 +++++++++++++++++
 tb/tb_fetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage. Issues in-order word reads to the
// instruction memory, buffers returned words with their PCs in a small FIFO
// and presents the FIFO head to decode. FLUSH redirects the stream and
// discards responses still in flight from the old stream.
//
// Optional feature macro: FETCH_MISALIGN_EN
//   defined   : FETCH_MISALIGN output; a FLUSH to a non-word-aligned NEW_PC
//               parks the stage (no fetches) presenting NEW_PC with a NOP.
//   undefined : NEW_PC[1:0] are forced to zero on redirect.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   FLUSH, NEW_PC       redirect request and target
//   STALL, MMU_WAIT     decode hold; head is not consumed
//   INST_RDEN/RDADDR    read request valid / word byte-address
//   INST_RDREADY        memory accepts the request this cycle
//   INST_RVALID/RDATA   in-order read response
//   FETCH_PC/FETCH_INST PC/instruction pair for decode (NOP bubble when empty)
//   FETCH_MISALIGN      misaligned redirect indication (optional)

module fetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic [31:0] NEW_PC,
  input  logic        STALL,
  input  logic        MMU_WAIT,
  output logic        INST_RDEN,
  output logic [31:0] INST_RDADDR,
  input  logic        INST_RDREADY,
  input  logic        INST_RVALID,
  input  logic [31:0] INST_RDATA,
  output logic [31:0] FETCH_PC,
  output logic [31:0] FETCH_INST
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        FETCH_MISALIGN
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Architectural state
  logic [31:0]   req_pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic [31:0]   tag_mem  [MAX_OUTSTANDING];
  logic [TW-1:0] tag_wr;
  logic [TW-1:0] tag_rd;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;

  // Per-cycle control
  logic          fifo_empty_c;
  logic          issue_c;
  logic          resp_c;
  logic          push_c;
  logic          pop_c;
  logic          hold_c;
  logic [31:0]   flush_pc_c;
  logic [OW-1:0] out_after_resp_c;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] idx);
    if (32'(idx) == MAX_OUTSTANDING - 1) return '0;
    return idx + TW'(1);
  endfunction

  // Misaligned-redirect park state (optional)
`ifdef FETCH_MISALIGN_EN
  logic        misalign_q;
  logic [31:0] misalign_pc_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      misalign_q    <= 1'b0;
      misalign_pc_q <= 32'h0;
    end else if (FLUSH) begin
      misalign_q    <= (NEW_PC[1:0] != 2'b00);
      misalign_pc_q <= NEW_PC;
    end
  end

  assign hold_c         = misalign_q;
  assign FETCH_MISALIGN = misalign_q;
`else
  assign hold_c = 1'b0;
`endif

  // Request/response/consume decisions
  always_comb begin
    fifo_empty_c     = (fifo_count == '0);
    flush_pc_c       = NEW_PC & ~32'h3;
    INST_RDADDR      = req_pc;
    // Reset gates the request so nothing is offered while held in reset.
    INST_RDEN        = RST_N && !FLUSH && !hold_c &&
                       (32'(outstanding) < MAX_OUTSTANDING) &&
                       ((32'(fifo_count) + 32'(outstanding)) < DEPTH);
    issue_c          = INST_RDEN && INST_RDREADY;
    resp_c           = INST_RVALID && (outstanding != '0);
    push_c           = resp_c && !FLUSH && (discard == '0) && !hold_c;
    pop_c            = !fifo_empty_c && !STALL && !MMU_WAIT && !FLUSH;
    out_after_resp_c = outstanding - OW'(resp_c);
  end

  // Decode-facing view of the FIFO head
  always_comb begin
    FETCH_PC   = 32'h0;
    FETCH_INST = NOP;
    if (!fifo_empty_c) begin
      FETCH_PC   = pc_mem[rd_ptr];
      FETCH_INST = inst_mem[rd_ptr];
    end
`ifdef FETCH_MISALIGN_EN
    if (misalign_q) begin
      FETCH_PC   = misalign_pc_q;
      FETCH_INST = NOP;
    end
`endif
  end

  // Control state
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      // Issue is blocked during FLUSH, so issue_c only matters outside it.
      outstanding <= out_after_resp_c + OW'(issue_c);
      if (issue_c) tag_wr <= tag_next(tag_wr);
      if (resp_c)  tag_rd <= tag_next(tag_rd);

      if (FLUSH) begin
        req_pc     <= flush_pc_c;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        discard    <= out_after_resp_c;
      end else begin
        if (issue_c) req_pc <= req_pc + 32'd4;
        if (push_c)  wr_ptr <= wr_ptr + AW'(1);
        if (pop_c)   rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push_c) - CW'(pop_c);
        if (resp_c && (discard != '0)) discard <= discard - OW'(1);
      end
    end
  end

  // Data storage (no reset needed; validity is tracked by the pointers)
  always_ff @(posedge CLK) begin
    if (issue_c) tag_mem[tag_wr] <= req_pc;
    if (push_c) begin
      pc_mem[wr_ptr]   <= tag_mem[tag_rd];
      inst_mem[wr_ptr] <= INST_RDATA;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scripted stimulus loads the expected
// PC stream into a scoreboard queue; a monitor pops and compares each time
// decode consumes a non-bubble FETCH_* pair. A latency-programmable memory
// model answers in order with RDATA = addr ^ 32'hA5A5_0000.

module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        CLK          = 1'b0;
  logic        RST_N        = 1'b0;
  logic        FLUSH        = 1'b0;
  logic [31:0] NEW_PC       = 32'h0;
  logic        STALL        = 1'b0;
  logic        MMU_WAIT     = 1'b0;
  logic        INST_RDEN;
  logic [31:0] INST_RDADDR;
  logic        INST_RDREADY = 1'b1;
  logic        INST_RVALID  = 1'b0;
  logic [31:0] INST_RDATA   = 32'h0;
  logic [31:0] FETCH_PC;
  logic [31:0] FETCH_INST;
`ifdef FETCH_MISALIGN_EN
  logic        FETCH_MISALIGN;
`endif

  fetch_queue dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .FLUSH        (FLUSH),
    .NEW_PC       (NEW_PC),
    .STALL        (STALL),
    .MMU_WAIT     (MMU_WAIT),
    .INST_RDEN    (INST_RDEN),
    .INST_RDADDR  (INST_RDADDR),
    .INST_RDREADY (INST_RDREADY),
    .INST_RVALID  (INST_RVALID),
    .INST_RDATA   (INST_RDATA),
    .FETCH_PC     (FETCH_PC),
    .FETCH_INST   (FETCH_INST)
`ifdef FETCH_MISALIGN_EN
    ,
    .FETCH_MISALIGN (FETCH_MISALIGN)
`endif
  );

  always #5 CLK = ~CLK;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_pc_q [$];
  logic [31:0] mem_addr_q [$];
  int          mem_due_q [$];
  int          cyc = 0;
  int          lat = 1;
  bit          mem_hold = 1'b0;
  logic [31:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: capture accepted requests, answer in order after lat cycles
  always @(negedge CLK) begin
    if (RST_N && INST_RDEN && INST_RDREADY) begin
      mem_addr_q.push_back(INST_RDADDR);
      mem_due_q.push_back(cyc + lat);
    end
  end

  always @(posedge CLK) begin
    cyc++;
    #1;
    if (!mem_hold && mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
      INST_RVALID = 1'b1;
      INST_RDATA  = mem_addr_q.pop_front() ^ KEY;
      void'(mem_due_q.pop_front());
    end else begin
      INST_RVALID = 1'b0;
    end
  end

  // Monitor: compare every consumed non-bubble pair against the scoreboard
  always @(negedge CLK) begin
    if (RST_N && !STALL && !MMU_WAIT && !FLUSH && (FETCH_INST !== NOP)) begin
      if (exp_pc_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got pc %h inst %h expected none", FETCH_PC, FETCH_INST);
      end else begin
        mon_e = exp_pc_q.pop_front();
        chk("stream_pc", FETCH_PC, mon_e);
        chk("stream_inst", FETCH_INST, mon_e ^ KEY);
      end
    end
  end

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_pc_q.push_back(start + 32'(4 * i));
  endtask

  task automatic flush_to(input logic [31:0] pc);
    @(posedge CLK); #1;
    FLUSH  = 1'b1;
    NEW_PC = pc;
    @(posedge CLK); #1;
    FLUSH  = 1'b0;
  endtask

  // Run until the scoreboard is empty, then stall decode
  task automatic drain(input int budget, input bit mmu_toggle);
    int k = 0;
    while (exp_pc_q.size() != 0 && k < budget) begin
      @(posedge CLK); #1;
      MMU_WAIT = mmu_toggle ? ~MMU_WAIT : 1'b0;
      k++;
    end
    STALL    = 1'b1;
    MMU_WAIT = 1'b0;
    chk("drain_remaining", 32'(exp_pc_q.size()), 32'd0);
    exp_pc_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rden", 32'(INST_RDEN), 32'd0);
    chk("rst_rdaddr", INST_RDADDR, 32'h0);
    chk("rst_fetch_pc", FETCH_PC, 32'h0);
    chk("rst_fetch_inst", FETCH_INST, NOP);

    // Straight-line fetch from reset
    push_stream(32'h0, 8);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (FETCH_INST !== NOP) break;
    end
    chk("first_latency_le3", 32'(k <= 3), 32'd1);
    drain(100, 1'b0);

    // Long stall: head frozen at 0x20, requests stop once buffers are full
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("stall_pc", FETCH_PC, 32'h20);
      chk("stall_inst", FETCH_INST, 32'h20 ^ KEY);
    end
    chk("stall_rden", 32'(INST_RDEN), 32'd0);
    push_stream(32'h20, 8);
    @(posedge CLK); #1;
    STALL = 1'b0;
    drain(100, 1'b0);

    // Two reads in flight (0x10, 0x14) dropped by a redirect to 0x100
    repeat (8) @(posedge CLK);
    #1 mem_hold = 1'b1;
    flush_to(32'h10);
    repeat (4) @(negedge CLK);
    chk("inflight_rdaddr", INST_RDADDR, 32'h18);
    chk("inflight_rden", 32'(INST_RDEN), 32'd0);
    push_stream(32'h100, 8);
    flush_to(32'h100);
    mem_hold = 1'b0;
    STALL    = 1'b0;
    drain(100, 1'b0);

    // Redirect to 0x200 in the same cycle a response arrives
    repeat (8) @(posedge CLK);
    #1 mem_hold = 1'b1;
    flush_to(32'h40);
    repeat (3) @(posedge CLK);
    #1 mem_hold = 1'b0;
    for (k = 0; k < 5; k++) begin
      @(posedge CLK); #2;
      if (INST_RVALID) break;
    end
    chk("flush_on_rvalid", 32'(INST_RVALID), 32'd1);
    FLUSH  = 1'b1;
    NEW_PC = 32'h200;
    push_stream(32'h200, 8);
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    STALL = 1'b0;
    drain(100, 1'b0);

    // Memory not ready: NOP bubbles, request address held
    repeat (8) @(posedge CLK);
    #1 INST_RDREADY = 1'b0;
    flush_to(32'h300);
    STALL = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bubble_inst", FETCH_INST, NOP);
      chk("bubble_pc", FETCH_PC, 32'h0);
      chk("bubble_rdaddr", INST_RDADDR, 32'h300);
    end
    push_stream(32'h300, 6);
    @(posedge CLK); #1;
    INST_RDREADY = 1'b1;
    drain(100, 1'b0);

    // Address wrap 0xFFFF_FFFC -> 0, with MMU_WAIT toggling
    push_stream(32'hFFFF_FFF8, 5);
    flush_to(32'hFFFF_FFF8);
    STALL = 1'b0;
    drain(200, 1'b1);

    // Misaligned redirect
`ifdef FETCH_MISALIGN_EN
    flush_to(32'h102);
    STALL = 1'b0;
    repeat (3) @(negedge CLK);
    chk("misalign_flag", 32'(FETCH_MISALIGN), 32'd1);
    chk("misalign_pc", FETCH_PC, 32'h102);
    chk("misalign_inst", FETCH_INST, NOP);
    chk("misalign_rden", 32'(INST_RDEN), 32'd0);
`else
    push_stream(32'h100, 4);
    flush_to(32'h102);
    STALL = 1'b0;
    drain(100, 1'b0);
`endif

    repeat (10) @(posedge CLK);
    chk("leftover", 32'(exp_pc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
